maxpool13_sched: RTL

- Sequencer for the shared combinational 13x13 FP16 max unit used by YOLO global/SPP pooling.
- Fetches 169 words per channel from a feature-map BRAM and assembles them into the max unit's window bus.
- Registers the max result and emits one result per channel on a valid/ready stream until `num_ch` channels are done.

---
 rtl/maxpool_pkg.sv | 26 ++
 rtl/maxpool13_sched_if.sv | 48 ++++
 rtl/maxpool13_win_buf.sv | 42 ++++
 rtl/maxpool13_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared constants and FSM encoding for the 13x13 FP16 max-pool sequencer.
//   WIN_DIM / WIN_ELEMS : window geometry (13x13 = 169 elements)
//   IDX_W               : width of the element index counter
//   FP16_ZERO           : positive zero, used by the optional ReLU clamp
//   state_t             : sequencer states
// -----------------------------------------------------------------------------
package maxpool_pkg;

    localparam int WIN_DIM   = 13;
    localparam int WIN_ELEMS = WIN_DIM * WIN_DIM;
    localparam int IDX_W     = $clog2(WIN_ELEMS);

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/maxpool13_sched_if.sv
// -----------------------------------------------------------------------------
// maxpool13_sched_if
// Bundles the job-control, BRAM-read, max-unit and result-stream signals of
// maxpool13_sched.
//   master : the environment (job issuer, BRAM, max unit, result consumer)
//   slave  : the sequencer itself
//
// Result stream handshake: a transfer happens on a rising clock edge where
// out_valid && out_ready are both high. Once out_valid rises, out_data and
// out_ch stay constant and out_valid stays high until that transfer; out_ready
// may toggle freely and has no effect while out_valid is low.
// -----------------------------------------------------------------------------
interface maxpool13_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 16,
    parameter int CH_W       = 10
);

    // job control
    logic                      start;
    logic [ADDR_W-1:0]         base_addr;
    logic [CH_W-1:0]           num_ch;
    logic                      busy;
    logic                      done;
    // feature-map BRAM read port
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    // shared combinational max unit
    logic [DATA_WIDTH*169-1:0] win;
    logic [DATA_WIDTH-1:0]     max_in;
    // result stream
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [CH_W-1:0]           out_ch;

    modport master (
        output start, base_addr, num_ch, rd_data, max_in, out_ready,
        input  busy, done, rd_en, rd_addr, win, out_valid, out_data, out_ch
    );

    modport slave (
        input  start, base_addr, num_ch, rd_data, max_in, out_ready,
        output busy, done, rd_en, rd_addr, win, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/maxpool13_win_buf.sv
// -----------------------------------------------------------------------------
// maxpool13_win_buf
// 169-entry window register. One element is written per cycle at i_wr_idx when
// i_wr_en is high; all entries are presented on the flat o_win bus, element k
// at bits [DATA_WIDTH*k +: DATA_WIDTH].
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (clears all entries)
//   i_wr_en        write strobe
//   i_wr_idx       element index to write (0..168)
//   i_wr_data      element value
//   o_win          flat window bus to the max unit
// -----------------------------------------------------------------------------
module maxpool13_win_buf
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_wr_en,
    input  logic [IDX_W-1:0]                i_wr_idx,
    input  logic [DATA_WIDTH-1:0]           i_wr_data,
    output logic [DATA_WIDTH*WIN_ELEMS-1:0] o_win
);

    logic [DATA_WIDTH-1:0] r_mem [WIN_ELEMS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < WIN_ELEMS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_wr_en && (int'(i_wr_idx) < WIN_ELEMS)) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    for (genvar g = 0; g < WIN_ELEMS; g++) begin : g_flat
        assign o_win[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
    end

endmodule

// File: rtl/maxpool13_sched.sv
// -----------------------------------------------------------------------------
// maxpool13_sched
// Sequencer for the shared combinational 13x13 FP16 max unit. For each of
// num_ch channels it reads 169 consecutive BRAM words into the window buffer,
// registers the max unit's result and offers it on a valid/ready stream.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          maxpool13_sched_if.slave (job control, BRAM read, window,
//                max input, result stream)
//   o_dbg_state  current FSM state
// Build option:
//   MAXPOOL_RELU_EN  when defined, negative results (sign bit set, including
//                    -0) are clamped to +0 at capture; timing is unchanged.
// -----------------------------------------------------------------------------
module maxpool13_sched
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 16,
    parameter int CH_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    maxpool13_sched_if.slave    bus,
    output state_t              o_dbg_state
);

    state_t                        r_state;
    state_t                        w_next;
    logic [IDX_W-1:0]              r_idx;
    logic [CH_W-1:0]               r_ch;
    logic [CH_W-1:0]               r_num_ch;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_WIDTH-1:0]         r_out_data;
    logic [CH_W-1:0]               r_out_ch;
    logic                          r_wr_en;
    logic [IDX_W-1:0]              r_wr_idx;
    logic [DATA_WIDTH-1:0]         w_cap_data;
    logic [DATA_WIDTH*WIN_ELEMS-1:0] w_win;
    logic                          w_hs;
    logic                          w_last_idx;
    logic                          w_last_ch;
    logic                          w_busy;
    logic                          w_done;
    logic                          w_rd_en;
    logic                          w_out_valid;

    assign w_last_idx = (r_idx == IDX_W'(WIN_ELEMS - 1));
    assign w_last_ch  = (r_ch == (r_num_ch - CH_W'(1)));
    assign w_hs       = w_out_valid && bus.out_ready;

`ifdef MAXPOOL_RELU_EN
    // Any set sign bit (including -0) clamps to +0.
    assign w_cap_data = bus.max_in[DATA_WIDTH-1] ? DATA_WIDTH'(FP16_ZERO) : bus.max_in;
`else
    assign w_cap_data = bus.max_in;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next      = r_state;
        w_busy      = (r_state != IDLE);
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num_ch == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                w_rd_en = 1'b1;
                if (w_last_idx) begin
                    w_next = DRAIN;
                end
            end
            DRAIN:   w_next = CAPTURE;
            CAPTURE: w_next = OUT;
            OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = w_last_ch ? DONE : FETCH;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counters, address and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_ch       <= '0;
            r_num_ch   <= '0;
            r_addr     <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            // BRAM data arrives one cycle after the strobe, so the window
            // write is the strobe and index delayed by one cycle.
            r_wr_en  <= w_rd_en;
            r_wr_idx <= r_idx;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_num_ch <= bus.num_ch;
                        r_ch     <= '0;
                        r_idx    <= '0;
                    end
                end
                FETCH: begin
                    // Address is never rewound: channel c starts at base + 169*c.
                    r_addr <= r_addr + ADDR_W'(1);
                    r_idx  <= w_last_idx ? '0 : (r_idx + IDX_W'(1));
                end
                CAPTURE: begin
                    r_out_data <= w_cap_data;
                    r_out_ch   <= r_ch;
                end
                OUT: begin
                    if (w_hs && !w_last_ch) begin
                        r_ch  <= r_ch + CH_W'(1);
                        r_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    maxpool13_win_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_win_buf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (r_wr_en),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.rd_data),
        .o_win     (w_win)
    );

    assign bus.win       = w_win;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = r_addr;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign o_dbg_state   = r_state;

endmodule
